// File: rtl/ser_pad_tx.sv
// ser_pad_tx -- transmitting end of the Gigatron controller link (SER_DATA).
//
// Emulates a 4021-style game pad. Bytes arrive through a small valid/ready
// FIFO. Each dequeued byte is presented for HOLD_FRAMES video frames. It is
// shifted MSB-first, clocked by the Gigatron's own HSYNC (OUT[6]) and loaded
// on VSYNC (OUT[7]) falling. When nothing is queued, IDLE_BYTE is sent.
//
// Ports:
//   CLK        block clock (pixel clock domain)
//   RST        asynchronous reset, active low
//   DIN        byte to transmit
//   DIN_VALID  DIN is valid
//   DIN_READY  FIFO can accept a byte (registered)
//   HSYNC      Gigatron OUT[6], shift clock, asynchronous to CLK
//   VSYNC      Gigatron OUT[7], active-low load strobe, asynchronous to CLK
//   SER_DATA   serial data towards PER (registered)
//   BUSY       FIFO non-empty or a hold still in progress (registered)
module ser_pad_tx #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned HOLD_FRAMES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] DIN,
   input  logic       DIN_VALID,
   output logic       DIN_READY,
   input  logic       HSYNC,
   input  logic       VSYNC,
   output logic       SER_DATA,
   output logic       BUSY
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned OW = PW + 1;
   localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

   // ---------------------------------------------------------------------
   // Sync-pin synchronizers and edge detect
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] hs_sync_q;
   logic [SYNC_STAGES-1:0] vs_sync_q;
   logic                   hs_prev_q;
   logic                   vs_prev_q;
   logic                   hs_s;
   logic                   vs_s;
   logic                   load_evt;
   logic                   shift_evt;

   // VSYNC idles high, so its chain resets high to avoid a false load.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hs_sync_q <= '0;
         vs_sync_q <= '1;
         hs_prev_q <= 1'b0;
         vs_prev_q <= 1'b1;
      end else begin
         hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], HSYNC};
         vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], VSYNC};
         hs_prev_q <= hs_s;
         vs_prev_q <= vs_s;
      end
   end

   assign hs_s      = hs_sync_q[SYNC_STAGES-1];
   assign vs_s      = vs_sync_q[SYNC_STAGES-1];
   assign load_evt  = vs_prev_q & ~vs_s;
   assign shift_evt = hs_s & ~hs_prev_q;

   // ---------------------------------------------------------------------
   // Input FIFO
   // ---------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          rdy_q, rdy_d;
   logic          push;
   logic          pop;

   // DIN_READY is the registered "not full" flag, so a full FIFO refuses
   // a push even in the cycle a pop frees an entry.
   assign push = DIN_VALID & rdy_q;

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= DIN;
      end
   end

   // ---------------------------------------------------------------------
   // Load / shift control
   // ---------------------------------------------------------------------
   logic [7:0] sr_q, sr_d;
   logic [7:0] cur_q, cur_d;
   logic [3:0] bcnt_q, bcnt_d;
   logic [3:0] hold_q, hold_d;
   logic       ser_q;
   logic       busy_q, busy_d;

   always_comb begin
      sr_d   = sr_q;
      cur_d  = cur_q;
      bcnt_d = bcnt_q;
      hold_d = hold_q;
      pop    = 1'b0;
      if (load_evt) begin
         // Load outranks a coincident shift.
         if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
            sr_d   = cur_q;
         end else if (occ_q != '0) begin
            pop    = 1'b1;
            cur_d  = mem_q[rd_ptr_q];
            sr_d   = mem_q[rd_ptr_q];
            hold_d = 4'(HOLD_FRAMES - 1);
         end else begin
            cur_d  = IDLE_BYTE;
            sr_d   = IDLE_BYTE;
         end
         bcnt_d = 4'd0;
      end else if (!vs_s) begin
         // Parallel-load is transparent while VSYNC is low: keep reloading.
         sr_d   = cur_q;
         bcnt_d = 4'd0;
      end else if (shift_evt && (bcnt_q < 4'd8)) begin
         // Ones fill in behind, so the line idles high once the byte is out.
         sr_d   = {sr_q[6:0], 1'b1};
         bcnt_d = bcnt_q + 4'd1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
      rdy_d  = (occ_d != OCC_FULL);
      busy_d = (occ_d != '0) | (hold_d != 4'd0);
   end

   // ---------------------------------------------------------------------
   // State registers and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sr_q     <= 8'hFF;
         cur_q    <= IDLE_BYTE;
         bcnt_q   <= 4'd8;
         hold_q   <= 4'd0;
         ser_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         cur_q    <= cur_d;
         bcnt_q   <= bcnt_d;
         hold_q   <= hold_d;
         ser_q    <= sr_q[7];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign SER_DATA  = ser_q;
   assign DIN_READY = rdy_q;
   assign BUSY      = busy_q;

endmodule

// File: doc/ser_pad_tx.md
Name: ser_pad_tx

Overview:
- Game-controller emulator: the transmitting end of the serial input link that PER receives on SER_DATA.
- Accepts bytes (button masks or ASCII codes) from an upstream source, such as a PS/2 decoder or a host bridge, through a valid/ready FIFO.
- Presents each byte to the Gigatron for HOLD_FRAMES consecutive video frames, shifted MSB-first.
- Timing is taken from the Gigatron's own sync outputs: VSYNC=OUT[7] and HSYNC=OUT[6]. This matches a 4021-style pad, which lets Pluggy-style keyboard input work without the physical controller.

Parameters:
- FIFO_DEPTH, 4, entries in the input FIFO; power of two, 2..16.
- HOLD_FRAMES, 2, frames each dequeued byte is repeated; 1..15.
- IDLE_BYTE, 8'hFF, byte shifted when there is nothing to send (no buttons pressed, active-low).
- SYNC_STAGES, 2, synchronizer flops on HSYNC and VSYNC; 2..3.

Ports:
- CLK  in  1  block clock (hdmi_pixel_clk domain, 26 MHz).
- RST  in  1  asynchronous, active-low reset.
- DIN  in  8  byte to transmit.
- DIN_VALID  in  1  DIN is valid.
- DIN_READY  out  1  FIFO can accept a byte.
- HSYNC  in  1  Gigatron OUT[6], shift clock, asynchronous to CLK.
- VSYNC  in  1  Gigatron OUT[7], active-low load strobe, asynchronous to CLK.
- SER_DATA  out  1  serial data to PER.
- BUSY  out  1  FIFO non-empty or hold in progress.

Behaviour:
- Reset (RST low, asynchronous):
  - SR=8'hFF, bit count=8, hold count=0, FIFO empty.
  - SER_DATA=1, DIN_READY=0, BUSY=0.
  - DIN_READY rises on the first CLK edge after RST is released.
  - A reset asserted mid-frame forces SER_DATA=1 at once. The frame in progress is lost.
- Synchronization:
  - HSYNC and VSYNC pass through SYNC_STAGES flops, then a one-flop edge detect.
  - A pin edge is acted on SYNC_STAGES+1 CLK cycles after it occurs. SER_DATA is registered, so it updates one cycle after the action.
- FIFO:
  - Push when DIN_VALID & DIN_READY.
  - DIN_READY = !full, registered from the occupancy at the previous edge. A push that coincides with a pop while full is refused; no bypass.
  - Byte order is preserved.
  - Occupancy counter width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Load event (synchronized VSYNC falling edge):
  - If hold count>0: reload the current byte; hold count -= 1.
  - Else if the FIFO is non-empty: pop, make it the current byte, hold count = HOLD_FRAMES-1.
  - Else: current byte = IDLE_BYTE.
  - In every case: SR <= current byte, bit count <= 0, SER_DATA <= SR[7] on the next cycle.
- Shift event (synchronized HSYNC rising edge, VSYNC high, bit count<8):
  - SR <= {SR[6:0],1'b1}; bit count += 1.
  - After the 8th shift, SER_DATA stays 1 until the next load.
- Ignored HSYNC edges:
  - HSYNC rising while VSYNC is low (during the vsync pulse, register transparent): no shift; SR keeps reloading.
  - HSYNC rising when bit count=8: SR unchanged.
- Collision: a load and a shift detected in the same cycle means the load wins and the shift is dropped.
- BUSY = (occupancy!=0) | (hold count!=0), registered.
- Missing VSYNC: SER_DATA stays at the last shifted value (1 once the byte is complete). No timeout.

Test Plan:
- Reset release, no DIN, 3 frames (VSYNC low 2 lines, 521 HSYNC per frame) -> SER_DATA reads 8'hFF MSB-first each frame; BUSY=0; DIN_READY=1 one cycle after reset release.
- Push 8'hA5, HOLD_FRAMES=2 -> frames 1 and 2 shift 1,0,1,0,0,1,0,1, then SER_DATA=1 for the rest of each frame; frame 3 shifts 8'hFF; BUSY falls at the frame-2 load.
- Push 5 bytes 8'h01..8'h05 back-to-back, FIFO_DEPTH=4 -> DIN_READY low after the 4th push; the 5th is accepted after the first load pops. Output order is 01,01,02,02,03,03,04,04,05,05 across frames.
- VSYNC falling and HSYNC rising within the same CLK cycle, queued byte 8'h80 -> load taken, shift dropped; first SER_DATA bit=1, second bit=0.
- HSYNC edges during the VSYNC-low pulse -> no shift; after VSYNC rises, the first HSYNC shifts bit 6 out. SER_DATA shows SYNC_STAGES+2 cycles after the pin edge.
- RST pulsed mid-shift (byte 8'h00, 3 bits sent) -> SER_DATA=1 immediately; FIFO empty; the next frame shifts 8'hFF.
